riscv_test_monitor: RTL and testbench
=====================================

// Module: riscv_test_monitor
// PURPOSE
//  Synthesisable pass/fail monitor for riscv-tests programs. Sits beside the core and snoops the
//  regfile write-back port; no hierarchical references. Register indices, magic values, settle
//  delay and timeout are parameters. Adds what the old bench check lacked: timeout detection,
//  captured fail test number, cycle count and sticky status, usable in sim and on FPGA.
// PARAMETERS
//  DATA_W         32    regfile data width
//  ADDR_W         5     regfile address width
//  DONE_REG       26    register whose write of DONE_VALUE ends the test
//  PASS_REG       27    register holding PASS_VALUE on success
//  TESTNUM_REG    3     register holding the failing test number
//  DONE_VALUE     1     value of DONE_REG that signals end of test
//  PASS_VALUE     1     value of PASS_REG that means pass
//  SETTLE_CYCLES  5     cycles waited after done before sampling PASS_REG (>=1)
//  TIMEOUT_CYCLES 1000  RUN cycles before timeout is declared (>=1)
//  CNT_W          32    width of the cycle counter
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       asynchronous active-low reset
//  en_i           in   1       start monitoring (level; sampled in IDLE)
//  wb_we_i        in   1       regfile write enable
//  wb_waddr_i     in   ADDR_W  regfile write address
//  wb_wdata_i     in   DATA_W  regfile write data
//  done_o         out  1       test finished: pass, fail or timeout (sticky)
//  pass_o         out  1       finished and PASS_REG==PASS_VALUE (sticky)
//  fail_o         out  1       finished and PASS_REG!=PASS_VALUE (sticky)
//  timeout_o      out  1       TIMEOUT_CYCLES elapsed with no done write (sticky)
//  fail_testnum_o out  DATA_W  TESTNUM_REG shadow captured at fail; 0 otherwise
//  cycle_cnt_o    out  CNT_W   RUN+SETTLE cycles counted; saturates at all-ones
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; all outputs 0; shadows of PASS_REG and TESTNUM_REG 0.
//  - Shadows: on a clk edge with wb_we_i=1 and wb_waddr_i==PASS_REG (or TESTNUM_REG), the
//    shadow takes wb_wdata_i. Shadows update in every state except FINISH. wb_waddr_i==0 is
//    always ignored (x0 is hardwired), even if a REG parameter is 0.
//  - FSM: IDLE -> RUN when en_i=1 (cycle counter cleared, counting starts next cycle).
//    RUN: counter +1 per cycle. A write of DONE_VALUE to DONE_REG -> SETTLE, settle counter
//    loaded with SETTLE_CYCLES. A write of any other value to DONE_REG is ignored. When the
//    counter reaches TIMEOUT_CYCLES with no done write -> FINISH with timeout_o=1, fail_o=1,
//    done_o=1, fail_testnum_o=0. A done write in the same cycle the timeout would fire takes
//    priority: go to SETTLE.
//    SETTLE: counter keeps incrementing, settle counter -1 per cycle, no timeout check. At
//    settle==0 the PASS_REG shadow, including any write in that same cycle, is compared:
//    equal -> pass_o=1; else -> fail_o=1, fail_testnum_o=TESTNUM shadow. done_o=1 -> FINISH.
//    FINISH: terminal. Outputs hold, cycle_cnt_o frozen, en_i and writes ignored until reset.
//  - Latency: done_o rises exactly SETTLE_CYCLES+1 edges after the done write edge.
//  - en_i deasserting after RUN has started has no effect. Only reset aborts a run; reset in
//    RUN or SETTLE returns to IDLE with all outputs 0.
//  - pass_o, fail_o and timeout_o are set in the same cycle as done_o; pass_o&fail_o is never 1.
// TESTING
//  1 en=1; write x27=1, then x26=1 -> after SETTLE_CYCLES+1: done=1, pass=1, fail=0, testnum=0.
//  2 write x3=7, x27=0, x26=1 -> done=1, fail=1, pass=0, fail_testnum_o=7.
//  3 en=1, no writes, TIMEOUT_CYCLES=50 -> at cycle 50: done=1, timeout=1, fail=1, cnt=50.
//  4 write x26=2 (ignored), then write x0=1 -> still RUN; then x26=1 with x27=1 -> pass.
//  5 x27=0, x26=1, then x27=1 during SETTLE -> pass=1; also assert timeout and done in the
//    same cycle -> SETTLE, not timeout.
//  6 pull rst_n low mid-SETTLE -> all outputs 0 at once; new run with en=1 passes normally.

Source files
------------

// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: snoops regfile write-back to report pass/fail/timeout of a riscv-tests run,
// with captured failing test number and a saturating run-length counter.
module riscv_test_monitor #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 5,
    parameter int DONE_REG       = 26,
    parameter int PASS_REG       = 27,
    parameter int TESTNUM_REG    = 3,
    parameter int DONE_VALUE     = 1,
    parameter int PASS_VALUE     = 1,
    parameter int SETTLE_CYCLES  = 5,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int CNT_W          = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_waddr_i,
    input  logic [DATA_W-1:0] wb_wdata_i,
    output logic              done_o,
    output logic              pass_o,
    output logic              fail_o,
    output logic              timeout_o,
    output logic [DATA_W-1:0] fail_testnum_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);
    typedef enum logic [1:0] {IDLE, RUN, SETTLE, FINISH} state_t;
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    state_t state, state_n;
    logic [DATA_W-1:0] pass_sh, pass_sh_n, tn_sh, tn_sh_n, fail_tn_n;
    logic [SW-1:0] settle, settle_n;
    logic [CNT_W-1:0] cnt_n, cnt_inc;
    logic done_n, pass_n, fail_n, to_n, wr, done_wr;
    // x0 is hardwired, so its writes never reach a shadow or the done detector
    assign wr        = wb_we_i && wb_waddr_i != '0 && state != FINISH;
    assign done_wr   = wr && wb_waddr_i == ADDR_W'(DONE_REG) && wb_wdata_i == DATA_W'(DONE_VALUE);
    assign pass_sh_n = (wr && wb_waddr_i == ADDR_W'(PASS_REG)) ? wb_wdata_i : pass_sh;
    assign tn_sh_n   = (wr && wb_waddr_i == ADDR_W'(TESTNUM_REG)) ? wb_wdata_i : tn_sh;
    assign cnt_inc   = &cycle_cnt_o ? cycle_cnt_o : cycle_cnt_o + 1'b1;
    always_comb begin
        state_n   = state;
        cnt_n     = cycle_cnt_o;
        settle_n  = settle;
        done_n    = done_o;
        pass_n    = pass_o;
        fail_n    = fail_o;
        to_n      = timeout_o;
        fail_tn_n = fail_testnum_o;
        case (state)
            IDLE: if (en_i) begin
                state_n = RUN;
                cnt_n   = '0;
            end
            RUN: begin
                cnt_n = cnt_inc;
                // a done write wins over a timeout firing on the same edge
                if (done_wr) begin
                    state_n  = SETTLE;
                    settle_n = SW'(SETTLE_CYCLES);
                end else if (64'(cnt_inc) == 64'(TIMEOUT_CYCLES)) begin
                    state_n = FINISH;
                    done_n  = 1'b1;
                    fail_n  = 1'b1;
                    to_n    = 1'b1;
                end
            end
            SETTLE: begin
                cnt_n = cnt_inc;
                if (settle == '0) begin
                    state_n = FINISH;
                    done_n  = 1'b1;
                    if (pass_sh_n == DATA_W'(PASS_VALUE)) pass_n = 1'b1;
                    else begin
                        fail_n    = 1'b1;
                        fail_tn_n = tn_sh_n;
                    end
                end else settle_n = settle - 1'b1;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            pass_sh        <= '0;
            tn_sh          <= '0;
            settle         <= '0;
            cycle_cnt_o    <= '0;
            done_o         <= 1'b0;
            pass_o         <= 1'b0;
            fail_o         <= 1'b0;
            timeout_o      <= 1'b0;
            fail_testnum_o <= '0;
        end else begin
            state          <= state_n;
            pass_sh        <= pass_sh_n;
            tn_sh          <= tn_sh_n;
            settle         <= settle_n;
            cycle_cnt_o    <= cnt_n;
            done_o         <= done_n;
            pass_o         <= pass_n;
            fail_o         <= fail_n;
            timeout_o      <= to_n;
            fail_testnum_o <= fail_tn_n;
        end
    end
endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: scoreboard bench; expected results queued at the done write (or run
// start for timeouts) and checked when done_o rises.
module tb_riscv_test_monitor;
    localparam int S = 5;
    localparam int T = 50;
    typedef struct {
        logic        pass;
        logic        fail;
        logic        to;
        logic [31:0] tn;
        int          cnt;
        int          at;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0, en_i = 1'b0, wb_we_i = 1'b0;
    logic [4:0] wb_waddr_i = '0;
    logic [31:0] wb_wdata_i = '0;
    logic done_o, pass_o, fail_o, timeout_o;
    logic [31:0] fail_testnum_o, cycle_cnt_o;
    exp_t sb[$];
    int cyc = 0, start = 0, last = 0, n_chk = 0, n_fail = 0;

    riscv_test_monitor #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i),
        .wb_wdata_i(wb_wdata_i), .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o),
        .timeout_o(timeout_o), .fail_testnum_o(fail_testnum_o), .cycle_cnt_o(cycle_cnt_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en_i = 1'b0;
        wb_we_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        @(negedge clk);
        en_i = 1'b1;
        @(posedge clk);
        #1 start = cyc;
        en_i = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wb_we_i = 1'b1;
        wb_waddr_i = a;
        wb_wdata_i = d;
        @(posedge clk);
        #1 last = cyc;
        wb_we_i = 1'b0;
    endtask

    task automatic push(input logic p, input logic f, input logic t, input logic [31:0] tn,
                        input int fin);
        exp_t e;
        e.pass = p; e.fail = f; e.to = t; e.tn = tn; e.at = fin; e.cnt = fin - start;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        exp_t e;
        int k = 0;
        @(negedge clk);
        while (!done_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_chk++;
        if (!done_o) begin
            n_fail++;
            $display("FAIL %s done_wait: done_o=0 after 200 cycles, required 1", name);
            return;
        end
        n_chk++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: done_o rose with no expected result queued", name);
            return;
        end
        e = sb.pop_front();
        n_chk++;
        if (cyc !== e.at) begin n_fail++; $display("FAIL %s latency: done at edge %0d, required %0d", name, cyc, e.at); end
        n_chk++;
        if (pass_o !== e.pass) begin n_fail++; $display("FAIL %s pass: got %b, required %b", name, pass_o, e.pass); end
        n_chk++;
        if (fail_o !== e.fail) begin n_fail++; $display("FAIL %s fail: got %b, required %b", name, fail_o, e.fail); end
        n_chk++;
        if (timeout_o !== e.to) begin n_fail++; $display("FAIL %s timeout: got %b, required %b", name, timeout_o, e.to); end
        n_chk++;
        if (fail_testnum_o !== e.tn) begin n_fail++; $display("FAIL %s testnum: got %0d, required %0d", name, fail_testnum_o, e.tn); end
        n_chk++;
        if (cycle_cnt_o !== 32'(e.cnt)) begin n_fail++; $display("FAIL %s cnt: got %0d, required %0d", name, cycle_cnt_o, e.cnt); end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_chk++;
        if ({done_o, pass_o, fail_o, timeout_o} !== 4'b0) begin n_fail++; $display("FAIL reset flags: got %b, required 0000", {done_o, pass_o, fail_o, timeout_o}); end
        n_chk++;
        if (fail_testnum_o !== 32'd0) begin n_fail++; $display("FAIL reset testnum: got %0d, required 0", fail_testnum_o); end
        n_chk++;
        if (cycle_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset cnt: got %0d, required 0", cycle_cnt_o); end
    endtask

    task automatic test_pass();
        int c;
        apply_reset();
        start_run();
        wb_write(5'd27, 32'd1);
        wb_write(5'd26, 32'd1);
        push(1'b1, 1'b0, 1'b0, 32'd0, last + S + 1);
        wait_done("pass");
        c = last + S + 1 - start;
        en_i = 1'b1;
        wb_write(5'd27, 32'd0);
        wb_write(5'd26, 32'd1);
        repeat (3) @(negedge clk);
        en_i = 1'b0;
        n_chk++;
        if ({done_o, pass_o, fail_o} !== 3'b110) begin n_fail++; $display("FAIL hold flags: got %b, required 110", {done_o, pass_o, fail_o}); end
        n_chk++;
        if (cycle_cnt_o !== 32'(c)) begin n_fail++; $display("FAIL hold cnt: got %0d, required %0d", cycle_cnt_o, c); end
    endtask

    task automatic test_fail();
        apply_reset();
        start_run();
        wb_write(5'd3, 32'd7);
        wb_write(5'd27, 32'd0);
        wb_write(5'd26, 32'd1);
        push(1'b0, 1'b1, 1'b0, 32'd7, last + S + 1);
        wait_done("fail");
    endtask

    task automatic test_timeout();
        apply_reset();
        start_run();
        push(1'b0, 1'b1, 1'b1, 32'd0, start + T);
        wait_done("timeout");
    endtask

    task automatic test_ignored();
        apply_reset();
        start_run();
        wb_write(5'd26, 32'd2);
        wb_write(5'd0, 32'd1);
        repeat (S + 3) @(negedge clk);
        n_chk++;
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL ignored done: got %b, required 0", done_o); end
        wb_write(5'd27, 32'd1);
        wb_write(5'd26, 32'd1);
        push(1'b1, 1'b0, 1'b0, 32'd0, last + S + 1);
        wait_done("ignored");
    endtask

    task automatic test_settle_write();
        int d;
        apply_reset();
        start_run();
        wb_write(5'd27, 32'd0);
        wb_write(5'd26, 32'd1);
        d = last;
        push(1'b1, 1'b0, 1'b0, 32'd0, d + S + 1);
        repeat (S) @(posedge clk);
        wb_write(5'd27, 32'd1);
        n_chk++;
        if (last !== d + S + 1) begin n_fail++; $display("FAIL settle_write edge: wrote at %0d, required %0d", last, d + S + 1); end
        wait_done("settle_write");
    endtask

    task automatic test_done_vs_timeout();
        apply_reset();
        start_run();
        wb_write(5'd27, 32'd1);
        repeat (start + T - 1 - cyc) @(posedge clk);
        wb_write(5'd26, 32'd1);
        n_chk++;
        if (last !== start + T) begin n_fail++; $display("FAIL race edge: done write at %0d, required %0d", last, start + T); end
        push(1'b1, 1'b0, 1'b0, 32'd0, last + S + 1);
        wait_done("done_vs_timeout");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        start_run();
        wb_write(5'd27, 32'd1);
        wb_write(5'd26, 32'd1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (cycle_cnt_o !== 32'd0) begin n_fail++; $display("FAIL midreset cnt: got %0d, required 0", cycle_cnt_o); end
        n_chk++;
        if ({done_o, pass_o, fail_o, timeout_o} !== 4'b0) begin n_fail++; $display("FAIL midreset flags: got %b, required 0000", {done_o, pass_o, fail_o, timeout_o}); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (S + 3) @(negedge clk);
        n_chk++;
        if (done_o !== 1'b0) begin n_fail++; $display("FAIL midreset aborted: done_o=%b, required 0", done_o); end
        start_run();
        wb_write(5'd27, 32'd1);
        wb_write(5'd26, 32'd1);
        push(1'b1, 1'b0, 1'b0, 32'd0, last + S + 1);
        wait_done("after_reset");
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_ignored();
        test_settle_write();
        test_done_vs_timeout();
        test_reset_mid();
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
